cccd_axil_regbank: RTL and testbench
====================================

# cccd_axil_regbank

Parametrised AXI4-Lite slave register bank, the successor to the fixed four-register cccd control interface. It exposes C_NUM_RW read/write control registers and C_NUM_RO read-only status registers to the PS master. It adds byte-lane write strobes, per-register write pulses, and SLVERR responses for illegal accesses. It sits between the AXI interconnect and the cccd datapath, which consumes the flattened register outputs and supplies the status words.

## Interface
- C_DATA_WIDTH, 32, AXI data width; 32 or 64
- C_ADDR_WIDTH, 6, AXI address width; must satisfy C_ADDR_WIDTH >= clog2(C_NUM_RW+C_NUM_RO) + ADDR_LSB
- C_NUM_RW, 4, read/write register count, >= 1
- C_NUM_RO, 2, read-only status register count, >= 0
- C_RESET_VAL, 0, reset value of every RW register
- ADDR_LSB (localparam), clog2(C_DATA_WIDTH/8)

- ACLK  in  1  sole clock
- ARESETN  in  1  asynchronous, active-low reset
- S_AXI_AWADDR  in  C_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
- S_AXI_WDATA  in  C_DATA_WIDTH  write data
- S_AXI_WSTRB  in  C_DATA_WIDTH/8  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
- S_AXI_BRESP  out  2  OKAY=00, SLVERR=10
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
- S_AXI_ARADDR  in  C_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
- S_AXI_RDATA  out  C_DATA_WIDTH  read data
- S_AXI_RRESP  out  2  OKAY/SLVERR
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
- reg_out  out  C_NUM_RW*C_DATA_WIDTH  RW register contents; register k in bits [k*W +: W]
- wr_pulse  out  C_NUM_RW  one-cycle strobe per register on committed write
- status_in  in  max(C_NUM_RO,1)*C_DATA_WIDTH  status words, same packing

## Operation
- Register index = addr[C_ADDR_WIDTH-1:ADDR_LSB]; low ADDR_LSB bits are ignored.
- Index 0..C_NUM_RW-1: RW. Index C_NUM_RW..C_NUM_RW+C_NUM_RO-1: RO, returning status_in word (index-C_NUM_RW). Higher indices are unmapped.
- Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP.
  - IDLE: AWREADY=WREADY=1. AW only goes to HAVE_AW; W only goes to HAVE_W; both in the same cycle go directly to RESP with commit.
  - HAVE_AW: AWREADY=0, WREADY=1. On W handshake, commit and go to RESP.
  - HAVE_W: WREADY=0, AWREADY=1. On AW handshake, commit and go to RESP.
  - RESP: AWREADY=WREADY=0, BVALID=1. BVALID and BRESP are held until BREADY, then return to IDLE.
- Commit to an RW index: update each byte lane b where WSTRB[b]=1; other lanes are kept. Pulse wr_pulse[k] for one cycle, even when WSTRB=0. BRESP=OKAY.
- Commit to an RO or unmapped index: no register change, no pulse, BRESP=SLVERR.
- Read FSM states: IDLE (ARREADY=1, RVALID=0) and RESP (ARREADY=0, RVALID=1).
  - On AR handshake, go to RESP and latch RDATA/RRESP.
  - Held stable until RREADY, then return to IDLE.
- Read of an unmapped index: RDATA=0, RRESP=SLVERR. RW and RO reads: RRESP=OKAY.
- RO data is sampled from status_in at the AR handshake edge.
- Read and write paths are fully independent; one outstanding transaction per path.

## Timing
- Reset values (asynchronous, while ARESETN=0):
  - all READY, BVALID and RVALID = 0
  - BRESP = RRESP = 00, RDATA = 0, wr_pulse = 0
  - every RW register = C_RESET_VAL
- AWREADY, WREADY and ARREADY rise on the first ACLK edge after ARESETN deasserts.
- Write latency: BVALID is high the cycle after the final AW/W handshake. reg_out and wr_pulse update on that same edge.
- Read latency: RVALID is high the cycle after the AR handshake.
- Simultaneous read and write to the same RW register on the same edge: the read returns the old value.
- Back-to-back: with BREADY/RREADY held high, one write and one read complete every 2 cycles.
- Reset asserted mid-transaction: the transaction is abandoned and no B or R beat is issued. A write not yet committed does not modify any register.

## Test plan
- Sequential write then read back:
  - write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, with WSTRB=0xF
  - reading each back returns the same value with RRESP=OKAY
  - wr_pulse[0..3] each fire exactly once.
- Partial strobe: reg0=0xAABBCCDD, then write 0x11223344 with WSTRB=0b0101 -> read returns 0xAA22CC44.
- Channel ordering: W presented 3 cycles before AW, then a separate transaction with AW before W -> both commit correctly, BRESP=OKAY, BVALID 1 cycle after the last handshake.
- Illegal access, with status_in word0=0xCAFE0001:
  - read of 0x10 -> 0xCAFE0001, OKAY
  - write to 0x10 -> SLVERR, no change
  - read of 0x18 -> 0x0, SLVERR
- Backpressure: BREADY and RREADY held low for 5 cycles -> BVALID/RVALID, BRESP/RRESP and RDATA stay stable, and no new AW/AR is accepted.
- Reset mid-write: AW accepted, then ARESETN pulsed low before W -> no BVALID, reg0=C_RESET_VAL, and READY signals return 1 cycle after reset release.

Source files
------------

// File: rtl/cccd_axil_regbank.sv
// cccd_axil_regbank
// AXI4-Lite slave register bank for the cccd datapath. Exposes C_NUM_RW
// read/write control registers followed by C_NUM_RO read-only status words.
// Writes honour byte strobes and raise a one-cycle wr_pulse for the target
// register. Accesses to RO (write) or unmapped (read/write) indices get SLVERR.
//
// Ports:
//   ACLK, ARESETN       clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*     AXI4-Lite write address, data and response channels
//   S_AXI_AR*/R*        AXI4-Lite read address and data channels
//   reg_out             RW register contents, register k at [k*W +: W]
//   wr_pulse            one-cycle strobe per RW register on committed write
//   status_in           RO status words, word j at [j*W +: W]
module cccd_axil_regbank #(
  parameter int                      C_DATA_WIDTH = 32,
  parameter int                      C_ADDR_WIDTH = 6,
  parameter int                      C_NUM_RW     = 4,
  parameter int                      C_NUM_RO     = 2,
  parameter logic [C_DATA_WIDTH-1:0] C_RESET_VAL  = '0
) (
  input  logic                                       ACLK,
  input  logic                                       ARESETN,
  input  logic [C_ADDR_WIDTH-1:0]                    S_AXI_AWADDR,
  input  logic [2:0]                                 S_AXI_AWPROT,
  input  logic                                       S_AXI_AWVALID,
  output logic                                       S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]                    S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]                  S_AXI_WSTRB,
  input  logic                                       S_AXI_WVALID,
  output logic                                       S_AXI_WREADY,
  output logic [1:0]                                 S_AXI_BRESP,
  output logic                                       S_AXI_BVALID,
  input  logic                                       S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]                    S_AXI_ARADDR,
  input  logic [2:0]                                 S_AXI_ARPROT,
  input  logic                                       S_AXI_ARVALID,
  output logic                                       S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]                    S_AXI_RDATA,
  output logic [1:0]                                 S_AXI_RRESP,
  output logic                                       S_AXI_RVALID,
  input  logic                                       S_AXI_RREADY,
  output logic [C_NUM_RW*C_DATA_WIDTH-1:0]           reg_out,
  output logic [C_NUM_RW-1:0]                        wr_pulse,
  input  logic [((C_NUM_RO > 0) ? C_NUM_RO : 1)*C_DATA_WIDTH-1:0] status_in
);

  localparam int ADDR_LSB = $clog2(C_DATA_WIDTH/8);
  localparam int STRB_W   = C_DATA_WIDTH/8;
  localparam int IDX_W    = C_ADDR_WIDTH - ADDR_LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE    = 2'd0;
  localparam logic [1:0] W_HAVE_AW = 2'd1;
  localparam logic [1:0] W_HAVE_W  = 2'd2;
  localparam logic [1:0] W_RESP    = 2'd3;

  logic [C_DATA_WIDTH-1:0] regs [C_NUM_RW];

  // Held low through reset and for the first edge after it, so the READY
  // outputs only rise on the first clock edge after ARESETN deasserts.
  logic ready_en;

  // ---------------- write path ----------------
  logic [1:0]              wstate;
  logic                    aw_hs, w_hs, commit;
  logic [IDX_W-1:0]        aw_idx_q, wr_idx;
  logic [C_DATA_WIDTH-1:0] wdata_q, wr_data;
  logic [STRB_W-1:0]       wstrb_q, wr_strb;
  logic [31:0]             wr_sel;
  logic                    wr_is_rw;
  logic [1:0]              bresp_q;

  assign S_AXI_AWREADY = ready_en && (wstate == W_IDLE || wstate == W_HAVE_W);
  assign S_AXI_WREADY  = ready_en && (wstate == W_IDLE || wstate == W_HAVE_AW);
  assign S_AXI_BVALID  = (wstate == W_RESP);
  assign S_AXI_BRESP   = bresp_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;

  // The final handshake commits; whichever half arrived earlier comes from
  // the holding registers, the half completing now comes straight off the bus.
  assign commit   = (wstate == W_IDLE    && aw_hs && w_hs) ||
                    (wstate == W_HAVE_AW && w_hs) ||
                    (wstate == W_HAVE_W  && aw_hs);
  assign wr_idx   = aw_hs ? S_AXI_AWADDR[C_ADDR_WIDTH-1:ADDR_LSB] : aw_idx_q;
  assign wr_data  = w_hs  ? S_AXI_WDATA : wdata_q;
  assign wr_strb  = w_hs  ? S_AXI_WSTRB : wstrb_q;
  assign wr_sel   = 32'(wr_idx);
  assign wr_is_rw = (wr_sel < 32'(C_NUM_RW));

  always_ff @(posedge ACLK) begin
    if (aw_hs) aw_idx_q <= S_AXI_AWADDR[C_ADDR_WIDTH-1:ADDR_LSB];
    if (w_hs) begin
      wdata_q <= S_AXI_WDATA;
      wstrb_q <= S_AXI_WSTRB;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en <= 1'b0;
      wstate   <= W_IDLE;
      bresp_q  <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      case (wstate)
        W_IDLE: begin
          if (aw_hs && w_hs) wstate <= W_RESP;
          else if (aw_hs)    wstate <= W_HAVE_AW;
          else if (w_hs)     wstate <= W_HAVE_W;
        end
        W_HAVE_AW: if (w_hs)         wstate <= W_RESP;
        W_HAVE_W:  if (aw_hs)        wstate <= W_RESP;
        default:   if (S_AXI_BREADY) wstate <= W_IDLE;
      endcase
      if (commit) bresp_q <= wr_is_rw ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < C_NUM_RW; k++) regs[k] <= C_RESET_VAL;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit && wr_is_rw) begin
        for (int k = 0; k < C_NUM_RW; k++) begin
          if (wr_sel == 32'(k)) begin
            wr_pulse[k] <= 1'b1;
            for (int b = 0; b < STRB_W; b++)
              if (wr_strb[b]) regs[k][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int k = 0; k < C_NUM_RW; k++) reg_out[k*C_DATA_WIDTH +: C_DATA_WIDTH] = regs[k];
  end

  // ---------------- read path ----------------
  logic                    rstate;
  logic                    ar_hs;
  logic [31:0]             rd_sel;
  logic [C_DATA_WIDTH-1:0] rd_mux, rdata_q;
  logic [1:0]              rd_resp_mux, rresp_q;

  assign S_AXI_ARREADY = ready_en && !rstate;
  assign S_AXI_RVALID  = rstate;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rd_sel = 32'(S_AXI_ARADDR[C_ADDR_WIDTH-1:ADDR_LSB]);

  always_comb begin
    rd_mux      = '0;
    rd_resp_mux = RESP_SLVERR;
    for (int k = 0; k < C_NUM_RW; k++) begin
      if (rd_sel == 32'(k)) begin
        rd_mux      = regs[k];
        rd_resp_mux = RESP_OKAY;
      end
    end
    for (int j = 0; j < C_NUM_RO; j++) begin
      if (rd_sel == 32'(C_NUM_RW + j)) begin
        rd_mux      = status_in[j*C_DATA_WIDTH +: C_DATA_WIDTH];
        rd_resp_mux = RESP_OKAY;
      end
    end
  end

  // Read data is captured from the pre-edge register value, so a write
  // committing on the same edge is not visible to this read.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstate  <= 1'b0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rstate  <= 1'b1;
      rdata_q <= rd_mux;
      rresp_q <= rd_resp_mux;
    end else if (rstate && S_AXI_RREADY) begin
      rstate  <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0], status_in};

endmodule

// File: tb/tb_cccd_axil_regbank.sv
module tb_cccd_axil_regbank;

  logic         clk;
  logic         rst_n;
  logic [5:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [5:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] reg_out;
  logic [3:0]   wr_pulse;
  logic [63:0]  status_in;

  int checks;
  int failures;
  int pulse_cnt [4];

  logic [1:0]  resp;
  logic [31:0] data;

  cccd_axil_regbank dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out),
    .wr_pulse      (wr_pulse),
    .status_in     (status_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) if (wr_pulse[k]) pulse_cnt[k] = pulse_cnt[k] + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    for (int k = 0; k < 4; k++) pulse_cnt[k] = 0;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin tick(); n++; end
    chk("wr_ready", {awready, wready}, 2'b11);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid", bvalid, 1'b1);
    r = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    chk("rd_ready", arready, 1'b1);
    tick();
    arvalid = 1'b0;
    chk("rd_rvalid", rvalid, 1'b1);
    d = rdata; r = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    clear_pulses();
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    status_in = {32'h0BAD0002, 32'hCAFE0001};

    // reset state
    tick(); tick();
    chk("rst_ctrl", {awready, wready, arready, bvalid, rvalid}, 5'b0);
    chk("rst_resp", {bresp, rresp, wr_pulse}, 8'h00);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_regout", reg_out, 128'h0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {awready, wready, arready}, 3'b000);
    tick();
    chk("ready_after_edge", {awready, wready, arready}, 3'b111);

    // sequential write/readback
    clear_pulses();
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(i*4), 32'(i+1), 4'hF, resp);
      chk("seq_bresp", resp, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(i*4), data, resp);
      chk("seq_rdata", data, 32'(i+1));
      chk("seq_rresp", resp, 2'b00);
    end
    for (int k = 0; k < 4; k++) chk("seq_pulse_cnt", 32'(pulse_cnt[k]), 32'd1);
    chk("seq_regout", reg_out, {32'h4, 32'h3, 32'h2, 32'h1});

    // partial strobe
    axi_write(6'h00, 32'hAABBCCDD, 4'hF, resp);
    axi_write(6'h00, 32'h11223344, 4'b0101, resp);
    chk("strb_bresp", resp, 2'b00);
    axi_read(6'h00, data, resp);
    chk("strb_rdata", data, 32'hAA22CC44);

    // W three cycles before AW, to reg1
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("wfirst_ready", {awready, wready, bvalid}, 3'b100);
    tick(); tick();
    chk("wfirst_wait", bvalid, 1'b0);
    awaddr = 6'h04; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("wfirst_bvalid", {bvalid, bresp}, 3'b100);
    chk("wfirst_reg1", reg_out[63:32], 32'h55);
    bready = 1'b1; tick(); bready = 1'b0;

    // AW before W, to reg2
    awaddr = 6'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("awfirst_ready", {awready, wready, bvalid}, 3'b010);
    tick();
    wdata = 32'h66; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("awfirst_bvalid", {bvalid, bresp}, 3'b100);
    chk("awfirst_reg2", reg_out[95:64], 32'h66);
    bready = 1'b1; tick(); bready = 1'b0;

    // illegal accesses
    clear_pulses();
    axi_read(6'h10, data, resp);
    chk("ro0_rdata", {data, resp}, {32'hCAFE0001, 2'b00});
    axi_read(6'h14, data, resp);
    chk("ro1_rdata", {data, resp}, {32'h0BAD0002, 2'b00});
    axi_write(6'h10, 32'hDEADBEEF, 4'hF, resp);
    chk("ro_write_bresp", resp, 2'b10);
    axi_write(6'h18, 32'hDEADBEEF, 4'hF, resp);
    chk("unmapped_write_bresp", resp, 2'b10);
    chk("illegal_regout", reg_out, {32'h4, 32'h66, 32'h55, 32'hAA22CC44});
    chk("illegal_pulses", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 32'd0);
    axi_read(6'h18, data, resp);
    chk("unmapped_read", {data, resp}, {32'h0, 2'b10});

    // backpressure
    awaddr = 6'h0C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 6'h00; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    awaddr = 6'h04; wdata = 32'h99; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h04; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata},
          {3'b000, 1'b1, 2'b00, 1'b1, 2'b00, 32'hAA22CC44});
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    chk("bp_release", {bvalid, rvalid, awready, arready}, 4'b0011);
    chk("bp_regout", reg_out, {32'h77, 32'h66, 32'h55, 32'hAA22CC44});

    // reset in the middle of a write
    awaddr = 6'h00; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("mid_have_aw", {awready, wready}, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {awready, wready, arready, bvalid}, 4'b0000);
    chk("mid_rst_regout", reg_out, 128'h0);
    tick();
    rst_n = 1'b1;
    wdata = 32'h12345678; wstrb = 4'hF;
    #1;
    chk("mid_ready_low", {awready, wready, arready}, 3'b000);
    tick();
    chk("mid_ready_high", {awready, wready, arready, bvalid}, 4'b1110);
    tick();
    chk("mid_no_b", bvalid, 1'b0);
    chk("mid_reg0", reg_out[31:0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
